// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and defaults for the ID/EX operand stage: datapath widths,
// the hard-wired zero register and the forwarding-source encoding.
package id_ex_operand_stage_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefAw    = 5;
    localparam int unsigned ZeroReg  = 0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MW,
        FWD_EM
    } fwd_src_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Forwarding mux for one source register field: the EX/MEM result beats the
// MEM/WB result, which beats the register file. Register 0 is never forwarded.
module id_ex_operand_stage_fwd_select
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned AW    = DefAw
) (
    input  logic [AW-1:0]    src_i,
    input  logic [WIDTH-1:0] rf_data_i,
    input  logic             em_we_i,
    input  logic [AW-1:0]    em_waddr_i,
    input  logic [WIDTH-1:0] em_data_i,
    input  logic             mw_we_i,
    input  logic [AW-1:0]    mw_waddr_i,
    input  logic [WIDTH-1:0] mw_data_i,
    output logic [WIDTH-1:0] data_o,
    output fwd_src_e         sel_o
);

    logic src_nz;
    assign src_nz = (src_i != AW'(ZeroReg));

    always_comb begin
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        if (src_nz && em_we_i && (em_waddr_i == src_i)) begin
            sel_o  = FWD_EM;
            data_o = em_data_i;
        end else if (src_nz && mw_we_i && (mw_waddr_i == src_i)) begin
            sel_o  = FWD_MW;
            data_o = mw_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, immediate/destination
// selection, load-use bubble insertion and a saturating stall counter.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned AW     = DefAw,
    parameter int unsigned SCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [AW-1:0]     id_rs_i,
    input  logic [AW-1:0]     id_rt_i,
    input  logic [AW-1:0]     id_rd_i,
    input  logic [WIDTH-1:0]  id_rd1_i,
    input  logic [WIDTH-1:0]  id_rd2_i,
    input  logic [WIDTH-1:0]  id_ext_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_dst_i,
    input  logic              id_reg_we_i,
    input  logic              id_is_load_i,
    input  logic              em_we_i,
    input  logic [AW-1:0]     em_waddr_i,
    input  logic [WIDTH-1:0]  em_data_i,
    input  logic              mw_we_i,
    input  logic [AW-1:0]     mw_waddr_i,
    input  logic [WIDTH-1:0]  mw_data_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stall_out_o,
    output logic              ex_valid_o,
    output logic [WIDTH-1:0]  ex_a_o,
    output logic [WIDTH-1:0]  ex_b_o,
    output logic [WIDTH-1:0]  ex_st_data_o,
    output logic [AW-1:0]     ex_waddr_o,
    output logic              ex_we_o,
    output logic              ex_is_load_o,
    output logic [SCNT_W-1:0] stall_cnt_o
);

    logic [WIDTH-1:0] rs_fwd, rt_fwd;
    fwd_src_e         rs_sel, rt_sel;

    id_ex_operand_stage_fwd_select #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_fwd_rs (
        .src_i      (id_rs_i),
        .rf_data_i  (id_rd1_i),
        .em_we_i    (em_we_i),
        .em_waddr_i (em_waddr_i),
        .em_data_i  (em_data_i),
        .mw_we_i    (mw_we_i),
        .mw_waddr_i (mw_waddr_i),
        .mw_data_i  (mw_data_i),
        .data_o     (rs_fwd),
        .sel_o      (rs_sel)
    );

    id_ex_operand_stage_fwd_select #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_fwd_rt (
        .src_i      (id_rt_i),
        .rf_data_i  (id_rd2_i),
        .em_we_i    (em_we_i),
        .em_waddr_i (em_waddr_i),
        .em_data_i  (em_data_i),
        .mw_we_i    (mw_we_i),
        .mw_waddr_i (mw_waddr_i),
        .mw_data_i  (mw_data_i),
        .data_o     (rt_fwd),
        .sel_o      (rt_sel)
    );

    // Source tags are for debug visibility only; the datapath uses the muxed values.
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^{rs_sel, rt_sel};

    logic              ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]  ex_a_q, ex_a_d;
    logic [WIDTH-1:0]  ex_b_q, ex_b_d;
    logic [WIDTH-1:0]  ex_st_data_q, ex_st_data_d;
    logic [AW-1:0]     ex_waddr_q, ex_waddr_d;
    logic              ex_we_q, ex_we_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic          hazard;
    logic          bubble;
    logic [AW-1:0] dest;

    // The load's data is not ready until MEM/WB, so a dependent instruction
    // in ID must wait one cycle; id_alu_src is deliberately ignored here.
    assign hazard = ex_valid_q && ex_is_load_q && ex_we_q
                 && (ex_waddr_q != AW'(ZeroReg)) && id_valid_i
                 && ((ex_waddr_q == id_rs_i) || (ex_waddr_q == id_rt_i));

    assign stall_out_o = hazard | hold_i;
    assign bubble      = flush_i | hazard;
    assign dest        = id_reg_we_i ? (id_reg_dst_i ? id_rd_i : id_rt_i) : AW'(ZeroReg);

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_st_data_d = ex_st_data_q;
        ex_waddr_d   = ex_waddr_q;
        ex_we_d      = ex_we_q;
        ex_is_load_d = ex_is_load_q;
        stall_cnt_d  = stall_cnt_q;
        if (!hold_i) begin
            ex_a_d       = rs_fwd;
            ex_b_d       = id_alu_src_i ? id_ext_i : rt_fwd;
            ex_st_data_d = rt_fwd;
            ex_waddr_d   = dest;
            ex_valid_d   = id_valid_i && !bubble;
            ex_we_d      = id_valid_i && id_reg_we_i && !bubble;
            ex_is_load_d = id_valid_i && id_is_load_i && !bubble;
            if (hazard && (stall_cnt_q != {SCNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_st_data_q <= '0;
            ex_waddr_q   <= '0;
            ex_we_q      <= 1'b0;
            ex_is_load_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_st_data_q <= ex_st_data_d;
            ex_waddr_q   <= ex_waddr_d;
            ex_we_q      <= ex_we_d;
            ex_is_load_q <= ex_is_load_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_a_o       = ex_a_q;
    assign ex_b_o       = ex_b_q;
    assign ex_st_data_o = ex_st_data_q;
    assign ex_waddr_o   = ex_waddr_q;
    assign ex_we_o      = ex_we_q;
    assign ex_is_load_o = ex_is_load_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the ID/EX stage. A second DUT with a 2-bit counter checks saturation.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_alu_src, id_reg_dst, id_reg_we, id_is_load;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_ext;
    logic        em_we, mw_we, hold, flush;
    logic [4:0]  em_waddr, mw_waddr;
    logic [31:0] em_data, mw_data;

    logic        stall_out, ex_valid, ex_we, ex_is_load;
    logic [31:0] ex_a, ex_b, ex_st_data;
    logic [4:0]  ex_waddr;
    logic [15:0] stall_cnt;

    logic        s2_stall_out, s2_ex_valid, s2_ex_we, s2_ex_is_load;
    logic [31:0] s2_ex_a, s2_ex_b, s2_ex_st_data;
    logic [4:0]  s2_ex_waddr;
    logic [1:0]  s2_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk_i (clk), .rst_ni (rst_n),
        .id_valid_i (id_valid), .id_rs_i (id_rs), .id_rt_i (id_rt), .id_rd_i (id_rd),
        .id_rd1_i (id_rd1), .id_rd2_i (id_rd2), .id_ext_i (id_ext),
        .id_alu_src_i (id_alu_src), .id_reg_dst_i (id_reg_dst), .id_reg_we_i (id_reg_we),
        .id_is_load_i (id_is_load),
        .em_we_i (em_we), .em_waddr_i (em_waddr), .em_data_i (em_data),
        .mw_we_i (mw_we), .mw_waddr_i (mw_waddr), .mw_data_i (mw_data),
        .hold_i (hold), .flush_i (flush),
        .stall_out_o (stall_out), .ex_valid_o (ex_valid), .ex_a_o (ex_a), .ex_b_o (ex_b),
        .ex_st_data_o (ex_st_data), .ex_waddr_o (ex_waddr), .ex_we_o (ex_we),
        .ex_is_load_o (ex_is_load), .stall_cnt_o (stall_cnt)
    );

    id_ex_operand_stage #(.SCNT_W (2)) dut_sat (
        .clk_i (clk), .rst_ni (rst_n),
        .id_valid_i (id_valid), .id_rs_i (id_rs), .id_rt_i (id_rt), .id_rd_i (id_rd),
        .id_rd1_i (id_rd1), .id_rd2_i (id_rd2), .id_ext_i (id_ext),
        .id_alu_src_i (id_alu_src), .id_reg_dst_i (id_reg_dst), .id_reg_we_i (id_reg_we),
        .id_is_load_i (id_is_load),
        .em_we_i (em_we), .em_waddr_i (em_waddr), .em_data_i (em_data),
        .mw_we_i (mw_we), .mw_waddr_i (mw_waddr), .mw_data_i (mw_data),
        .hold_i (hold), .flush_i (flush),
        .stall_out_o (s2_stall_out), .ex_valid_o (s2_ex_valid), .ex_a_o (s2_ex_a),
        .ex_b_o (s2_ex_b), .ex_st_data_o (s2_ex_st_data), .ex_waddr_o (s2_ex_waddr),
        .ex_we_o (s2_ex_we), .ex_is_load_o (s2_ex_is_load), .stall_cnt_o (s2_stall_cnt)
    );

    task automatic idle_inputs();
        id_valid = 0; id_alu_src = 0; id_reg_dst = 0; id_reg_we = 0; id_is_load = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0; id_ext = 0;
        em_we = 0; em_waddr = 0; em_data = 0; mw_we = 0; mw_waddr = 0; mw_data = 0;
        hold = 0; flush = 0;
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        id_valid = 1; id_rs = 1; id_rd1 = 5; id_reg_we = 1; id_rt = 2;
        step();
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({ex_valid, ex_we, ex_is_load} !== 3'b000 || ex_a !== 0 || ex_b !== 0
            || ex_st_data !== 0 || ex_waddr !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL reset_async: valid=%0b a=%0h b=%0h st=%0h waddr=%0d cnt=%0d, want all 0",
                     ex_valid, ex_a, ex_b, ex_st_data, ex_waddr, stall_cnt);
        end
        #1;
        rst_n = 1;
        step();
    endtask

    task automatic test_double_forward();
        do_reset();
        id_valid = 1; id_rs = 3; id_rd1 = 32'h1111;
        em_we = 1; em_waddr = 3; em_data = 32'hAAAA;
        mw_we = 1; mw_waddr = 3; mw_data = 32'hBBBB;
        step();
        checks++;
        if (ex_a !== 32'hAAAA) begin
            errors++;
            $display("FAIL fwd_em_priority: ex_a=%0h want aaaa", ex_a);
        end
        em_we = 0;
        step();
        checks++;
        if (ex_a !== 32'hBBBB) begin
            errors++;
            $display("FAIL fwd_mw: ex_a=%0h want bbbb", ex_a);
        end
        mw_we = 0;
        step();
        checks++;
        if (ex_a !== 32'h1111) begin
            errors++;
            $display("FAIL fwd_rf: ex_a=%0h want 1111", ex_a);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        id_valid = 1; id_rt = 0; id_rd2 = 0; id_alu_src = 0;
        em_we = 1; em_waddr = 0; em_data = 7; mw_we = 1; mw_waddr = 0; mw_data = 9;
        step();
        checks++;
        if (ex_b !== 0 || ex_st_data !== 0) begin
            errors++;
            $display("FAIL zero_reg: ex_b=%0h st=%0h want 0 0", ex_b, ex_st_data);
        end
        // Immediate select and destination muxing on an R-type style write.
        id_rt = 4; id_rd = 6; id_rd2 = 32'h44; id_alu_src = 1; id_ext = 32'hFFFF_FFF0;
        id_reg_we = 1; id_reg_dst = 1; em_we = 0; mw_we = 0;
        step();
        checks++;
        if (ex_b !== 32'hFFFF_FFF0 || ex_st_data !== 32'h44 || ex_waddr !== 6 || ex_we !== 1) begin
            errors++;
            $display("FAIL imm_dst: b=%0h st=%0h waddr=%0d we=%0b want fffffff0 44 6 1",
                     ex_b, ex_st_data, ex_waddr, ex_we);
        end
        id_reg_we = 0;
        step();
        checks++;
        if (ex_waddr !== 0 || ex_we !== 0) begin
            errors++;
            $display("FAIL no_write_dst: waddr=%0d we=%0b want 0 0", ex_waddr, ex_we);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid = 1; id_is_load = 1; id_reg_we = 1; id_reg_dst = 0; id_rs = 2; id_rt = 8;
        step();
        id_is_load = 0; id_reg_dst = 1; id_rd = 9; id_rs = 8; id_rt = 0; id_rd1 = 32'hDEAD;
        #1;
        checks++;
        if (stall_out !== 1) begin
            errors++;
            $display("FAIL load_use_stall: stall_out=%0b want 1", stall_out);
        end
        step();
        checks++;
        if (ex_valid !== 0 || stall_cnt !== 1) begin
            errors++;
            $display("FAIL load_use_bubble: ex_valid=%0b cnt=%0d want 0 1", ex_valid, stall_cnt);
        end
        mw_we = 1; mw_waddr = 8; mw_data = 32'h1234;
        #1;
        checks++;
        if (stall_out !== 0) begin
            errors++;
            $display("FAIL load_use_release: stall_out=%0b want 0", stall_out);
        end
        step();
        checks++;
        if (ex_a !== 32'h1234 || ex_valid !== 1 || stall_cnt !== 1) begin
            errors++;
            $display("FAIL load_use_fwd: ex_a=%0h valid=%0b cnt=%0d want 1234 1 1",
                     ex_a, ex_valid, stall_cnt);
        end
    endtask

    task automatic test_hold_flush();
        do_reset();
        id_valid = 1; id_is_load = 1; id_reg_we = 1; id_rt = 5; id_rs = 1; id_rd1 = 32'h55;
        step();
        // Dependent instruction in ID while held: hazard is present but must not count.
        id_is_load = 0; id_rs = 5; id_rd1 = 32'h99; hold = 1; flush = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall_out !== 1) begin
                errors++;
                $display("FAIL hold_stall_out: cycle %0d stall_out=%0b want 1", i, stall_out);
            end
            step();
            checks++;
            if (ex_valid !== 1 || ex_is_load !== 1 || ex_a !== 32'h55 || ex_waddr !== 5
                || stall_cnt !== 0) begin
                errors++;
                $display("FAIL hold_keep: cycle %0d valid=%0b ld=%0b a=%0h waddr=%0d cnt=%0d",
                         i, ex_valid, ex_is_load, ex_a, ex_waddr, stall_cnt);
            end
        end
        hold = 0; id_rs = 1;
        step();
        checks++;
        if (ex_valid !== 0 || ex_we !== 0 || ex_is_load !== 0) begin
            errors++;
            $display("FAIL flush_after_hold: valid=%0b we=%0b ld=%0b want 0 0 0",
                     ex_valid, ex_we, ex_is_load);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            id_valid = 1; id_is_load = 1; id_reg_we = 1; id_rt = 8;
            step();
            id_is_load = 0; id_rt = 0; id_rs = 8;
            step();
        end
        idle_inputs();
        checks++;
        if (s2_stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt2: cnt=%0d want 3", s2_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL sat_cnt16: cnt=%0d want 5", stall_cnt);
        end
    endtask

    // Behavioural model of forwarding for one source field.
    function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] rf);
        if (s != 0 && em_we && em_waddr == s) return em_data;
        if (s != 0 && mw_we && mw_waddr == s) return mw_data;
        return rf;
    endfunction

    task automatic test_random();
        logic        m_valid, m_we, m_load, m_data_ok, haz, bub;
        logic [31:0] m_a, m_b, m_st;
        logic [4:0]  m_waddr;
        int          m_cnt, m_cnt2;
        do_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_data_ok = 1;
        m_a = 0; m_b = 0; m_st = 0; m_waddr = 0; m_cnt = 0; m_cnt2 = 0;
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_rd      = 5'($urandom_range(0, 3));
            id_rd1     = $urandom; id_rd2 = $urandom; id_ext = $urandom;
            id_alu_src = 1'($urandom_range(0, 1));
            id_reg_dst = 1'($urandom_range(0, 1));
            id_reg_we  = ($urandom_range(0, 3) != 0);
            id_is_load = ($urandom_range(0, 2) == 0);
            em_we      = 1'($urandom_range(0, 1));
            em_waddr   = 5'($urandom_range(0, 3));
            em_data    = $urandom;
            mw_we      = 1'($urandom_range(0, 1));
            mw_waddr   = 5'($urandom_range(0, 3));
            mw_data    = $urandom;
            hold       = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            #1;
            haz = m_valid && m_load && m_we && m_waddr != 0 && id_valid
                  && (m_waddr == id_rs || m_waddr == id_rt);
            checks++;
            if (stall_out !== (haz || hold)) begin
                errors++;
                $display("FAIL rand_stall_out: iter %0d got %0b want %0b", i, stall_out, haz || hold);
            end
            if (!hold) begin
                bub       = flush || haz;
                m_valid   = id_valid && !bub;
                m_we      = id_valid && id_reg_we && !bub;
                m_load    = id_valid && id_is_load && !bub;
                m_a       = model_fwd(id_rs, id_rd1);
                m_st      = model_fwd(id_rt, id_rd2);
                m_b       = id_alu_src ? id_ext : m_st;
                m_waddr   = !id_reg_we ? 5'd0 : (id_reg_dst ? id_rd : id_rt);
                m_data_ok = !bub;
                if (haz) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
            step();
            checks++;
            if (ex_valid !== m_valid || ex_we !== m_we || ex_is_load !== m_load) begin
                errors++;
                $display("FAIL rand_ctrl: iter %0d got v/we/ld=%0b%0b%0b want %0b%0b%0b",
                         i, ex_valid, ex_we, ex_is_load, m_valid, m_we, m_load);
            end
            checks++;
            if (stall_cnt !== 16'(m_cnt) || s2_stall_cnt !== 2'(m_cnt2)) begin
                errors++;
                $display("FAIL rand_cnt: iter %0d got %0d/%0d want %0d/%0d",
                         i, stall_cnt, s2_stall_cnt, m_cnt, m_cnt2);
            end
            if (m_data_ok) begin
                checks++;
                if (ex_a !== m_a || ex_b !== m_b || ex_st_data !== m_st || ex_waddr !== m_waddr) begin
                    errors++;
                    $display("FAIL rand_data: iter %0d got a=%0h b=%0h st=%0h wa=%0d want %0h %0h %0h %0d",
                             i, ex_a, ex_b, ex_st_data, ex_waddr, m_a, m_b, m_st, m_waddr);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        #2;
        test_reset();
        test_double_forward();
        test_zero_reg();
        test_load_use();
        test_hold_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
